// File: rtl/rs_sqrt_param.sv
// -----------------------------------------------------------------------------
// rs_sqrt_param
//
// Integer square root of an unsigned WIDTH-bit operand. It uses the restoring
// bit-pair algorithm and resolves one root bit per clock. After the request is
// accepted, the result appears RW = WIDTH/2 edges later and is held until the
// next operation completes.
//
// Parameters:
//   WIDTH    operand width (even, >= 4); root width RW = WIDTH/2
//   STATE_W  width of the exported state code
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   sqrt_start  request, sampled only in IDLE
//   data_in     operand, captured on the accepting edge
//   sqrt_done   one-cycle pulse, result valid
//   sqrt_busy   high from the accepting edge until DONE is left
//   data_out    floor(sqrt(operand))
//   rem_out     operand - data_out^2
//   perfect     remainder is zero
//   SQRTstate   current state code (IDLE=0, ITER=1, DONE=2)
// -----------------------------------------------------------------------------
module rs_sqrt_param #(
   parameter  int WIDTH   = 20,
   parameter  int STATE_W = 2,
   localparam int RW      = WIDTH / 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sqrt_start,
   input  logic [WIDTH-1:0]   data_in,
   output logic               sqrt_done,
   output logic               sqrt_busy,
   output logic [RW-1:0]      data_out,
   output logic [RW:0]        rem_out,
   output logic               perfect,
   output logic [STATE_W-1:0] SQRTstate
);

   localparam int CNT_W = (RW > 1) ? $clog2(RW) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2,
      BAD  = 2'd3
   } state_t;

   state_t           state_reg,   state_next;
   logic [WIDTH-1:0] op_reg,      op_next;
   logic [RW-1:0]    q_reg,       q_next;
   logic [RW+1:0]    r_reg,       r_next;
   logic [CNT_W-1:0] cnt_reg,     cnt_next;
   logic [RW-1:0]    root_reg,    root_next;
   logic [RW:0]      rem_reg,     rem_next;
   logic             perfect_reg, perfect_next;
   logic             done_reg,    done_next;
   logic             busy_reg,    busy_next;

   // One iteration of the bit-pair step, evaluated every cycle.
   logic [RW+1:0]    r_shift;
   logic [RW+1:0]    trial;
   logic [RW+1:0]    t_val;
   logic [RW-1:0]    q_iter;
   logic [RW+1:0]    r_iter;

   always_comb begin
      r_shift = (r_reg << 2) | {{RW{1'b0}}, op_reg[WIDTH-1 -: 2]};
      trial   = {q_reg, 2'b01};
      t_val   = r_shift - trial;
      // The MSB of the RW+2 bit difference is its sign. When it is set, the
      // trial subtraction failed, so keep the shifted remainder.
      if (!t_val[RW+1]) begin
         r_iter = t_val;
         q_iter = (q_reg << 1) | {{(RW-1){1'b0}}, 1'b1};
      end else begin
         r_iter = r_shift;
         q_iter = q_reg << 1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      op_next      = op_reg;
      q_next       = q_reg;
      r_next       = r_reg;
      cnt_next     = cnt_reg;
      root_next    = root_reg;
      rem_next     = rem_reg;
      perfect_next = perfect_reg;
      done_next    = 1'b0;
      busy_next    = busy_reg;

      case (state_reg)
         IDLE: begin
            busy_next = 1'b0;
            if (sqrt_start) begin
               op_next    = data_in;
               q_next     = '0;
               r_next     = '0;
               cnt_next   = CNT_W'(RW - 1);
               busy_next  = 1'b1;
               state_next = ITER;
            end
         end
         ITER: begin
            op_next = op_reg << 2;
            q_next  = q_iter;
            r_next  = r_iter;
            if (cnt_reg == '0) begin
               // Register the result on the edge that enters DONE.
               root_next    = q_iter;
               rem_next     = r_iter[RW:0];
               perfect_next = (r_iter == '0);
               done_next    = 1'b1;
               state_next   = DONE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         DONE: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            // Code 3 is unreachable in normal operation. Recover to IDLE.
            busy_next  = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         op_reg      <= '0;
         q_reg       <= '0;
         r_reg       <= '0;
         cnt_reg     <= '0;
         root_reg    <= '0;
         rem_reg     <= '0;
         perfect_reg <= 1'b0;
         done_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         op_reg      <= op_next;
         q_reg       <= q_next;
         r_reg       <= r_next;
         cnt_reg     <= cnt_next;
         root_reg    <= root_next;
         rem_reg     <= rem_next;
         perfect_reg <= perfect_next;
         done_reg    <= done_next;
         busy_reg    <= busy_next;
      end
   end

   assign sqrt_done = done_reg;
   assign sqrt_busy = busy_reg;
   assign data_out  = root_reg;
   assign rem_out   = rem_reg;
   assign perfect   = perfect_reg;
   assign SQRTstate = STATE_W'(state_reg);

endmodule

// File: tb/tb_rs_sqrt_param.sv
// -----------------------------------------------------------------------------
// tb_rs_sqrt_param
//
// Drives a WIDTH=20 instance and a WIDTH=8 instance of rs_sqrt_param. Each
// result is compared against an integer square root computed by plain search.
// -----------------------------------------------------------------------------
module tb_rs_sqrt_param;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH = 20 instance
   logic        rst20_n, st20;
   logic [19:0] din20;
   logic        done20, busy20, perf20;
   logic [9:0]  q20;
   logic [10:0] rem20;
   logic [1:0]  state20;

   // WIDTH = 8 instance
   logic        rst8_n, st8;
   logic [7:0]  din8;
   logic        done8, busy8, perf8;
   logic [3:0]  q8;
   logic [4:0]  rem8;
   logic [1:0]  state8;

   int vectors    = 0;
   int miscompares = 0;

   rs_sqrt_param #(.WIDTH(20), .STATE_W(2)) dut20 (
      .clock(clk), .reset(rst20_n), .sqrt_start(st20), .data_in(din20),
      .sqrt_done(done20), .sqrt_busy(busy20), .data_out(q20),
      .rem_out(rem20), .perfect(perf20), .SQRTstate(state20)
   );

   rs_sqrt_param #(.WIDTH(8), .STATE_W(2)) dut8 (
      .clock(clk), .reset(rst8_n), .sqrt_start(st8), .data_in(din8),
      .sqrt_done(done8), .sqrt_busy(busy8), .data_out(q8),
      .rem_out(rem8), .perfect(perf8), .SQRTstate(state8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input longint exp);
      vectors++;
      assert (obs === 64'(exp)) else begin
         miscompares++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: largest r such that r*r <= x
   function automatic longint isqrt(input longint x);
      longint r = 0;
      while ((r + 1) * (r + 1) <= x) r++;
      return r;
   endfunction

   task automatic run20(input logic [19:0] x, input bit full);
      int     edges;
      int     busy_cnt;
      longint eq, er;
      eq = isqrt(longint'(x));
      er = longint'(x) - eq * eq;
      @(negedge clk);
      din20 = x;
      st20  = 1'b1;
      @(negedge clk);                 // accepting edge has passed
      st20  = 1'b0;
      din20 = ~x;                     // later changes must not matter
      busy_cnt = int'(busy20);
      edges = 0;
      while (!done20 && edges < 40) begin
         @(negedge clk);
         edges++;
         if (busy20) busy_cnt++;
      end
      check("lat20", edges, 10);
      check("root20", q20, eq);
      check("rem20", rem20, er);
      check("perf20", perf20, (er == 0) ? 1 : 0);
      if (full) begin
         check("state_done20", state20, 2);
         check("busy_done20", busy20, 1);
      end
      @(negedge clk);
      check("done_pulse20", done20, 0);
      if (full) begin
         check("busy_cnt20", busy_cnt, 11);
         check("busy_idle20", busy20, 0);
         check("state_idle20", state20, 0);
         check("hold20", q20, eq);
      end
      $display("w20 op=%0d root=%0d rem=%0d perfect=%0d lat=%0d", x, q20, rem20, perf20, edges);
   endtask

   task automatic run8(input logic [7:0] x, input bit full);
      int     edges;
      int     busy_cnt;
      longint eq, er;
      eq = isqrt(longint'(x));
      er = longint'(x) - eq * eq;
      @(negedge clk);
      din8 = x;
      st8  = 1'b1;
      @(negedge clk);
      st8  = 1'b0;
      din8 = ~x;
      busy_cnt = int'(busy8);
      edges = 0;
      while (!done8 && edges < 20) begin
         @(negedge clk);
         edges++;
         if (busy8) busy_cnt++;
      end
      check("lat8", edges, 4);
      check("root8", q8, eq);
      check("rem8", rem8, er);
      check("perf8", perf8, (er == 0) ? 1 : 0);
      @(negedge clk);
      check("done_pulse8", done8, 0);
      if (full) begin
         check("busy_cnt8", busy_cnt, 5);
         check("state_idle8", state8, 0);
      end
      $display("w8  op=%0d root=%0d rem=%0d perfect=%0d lat=%0d", x, q8, rem8, perf8, edges);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [19:0] expq[$];
      logic [19:0] xq;
      longint      eq;
      int          last_done;
      int          dones;
      int          phase;
      int          rst_dones;

      rst20_n = 1'b0; rst8_n = 1'b0;
      st20 = 1'b0; st8 = 1'b0;
      din20 = '0;  din8 = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_state20", state20, 0);
      check("rst_done20", done20, 0);
      check("rst_busy20", busy20, 0);
      check("rst_root20", q20, 0);
      check("rst_rem20", rem20, 0);
      check("rst_perf20", perf20, 0);
      check("rst_state8", state8, 0);
      check("rst_root8", q8, 0);
      rst20_n = 1'b1;
      rst8_n  = 1'b1;

      // Directed operands
      run20(20'd0, 1'b1);
      run20(20'd1000, 1'b1);
      run20(20'd144, 1'b1);
      run20(20'd1048575, 1'b1);
      for (int i = 0; i < 6; i++) run20(20'($urandom), 1'b0);

      run8(8'd255, 1'b1);
      run8(8'd64, 1'b1);
      run8(8'd0, 1'b0);
      run8(8'd3, 1'b0);
      for (int i = 0; i < 4; i++) run8(8'($urandom), 1'b0);

      // Start held high while data_in changes every cycle.
      last_done = -1;
      dones     = 0;
      phase     = 0;
      for (int c = 0; c < 54; c++) begin
         if (done20) begin
            if (expq.size() == 0) begin
               check("spurious_done20", 1, 0);
            end else begin
               xq = expq.pop_front();
               eq = isqrt(longint'(xq));
               check("held_root20", q20, eq);
               check("held_rem20", rem20, longint'(xq) - eq * eq);
               $display("held op=%0d root=%0d rem=%0d cycle=%0d", xq, q20, rem20, c);
            end
            if (last_done >= 0) check("done_spacing20", c - last_done, 12);
            last_done = c;
            dones++;
         end
         if (c < 40) begin
            check("held_state20", state20, (phase == 0) ? 0 : (phase == 11) ? 2 : 1);
            phase = (phase + 1) % 12;
            st20  = 1'b1;
            din20 = 20'($urandom);
            if (state20 == 2'd0) expq.push_back(din20);
         end else begin
            st20 = 1'b0;
         end
         @(negedge clk);
      end
      check("held_dones20", dones, 4);
      check("held_queue20", expq.size(), 0);

      // Asynchronous reset during the 5th iteration
      run20(20'd1048575, 1'b0);
      @(negedge clk);
      din20 = 20'd777777;
      st20  = 1'b1;
      @(negedge clk);
      st20  = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst20_n = 1'b0;
      #1;
      check("abort_state20", state20, 0);
      check("abort_root20", q20, 0);
      check("abort_rem20", rem20, 0);
      check("abort_busy20", busy20, 0);
      check("abort_perf20", perf20, 0);
      rst_dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done20) rst_dones++;
      end
      check("abort_no_done20", rst_dones, 0);
      rst20_n = 1'b1;
      run20(20'd777777, 1'b1);
      run20(20'($urandom), 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rs_sqrt_param.md
Name: rs_sqrt_param

Overview:
- Parametrised successor to the fixed 20-bit integer square-root unit.
- Computes floor(sqrt(data_in)) and the remainder for an unsigned operand of WIDTH bits using the restoring bit-pair algorithm, one root bit per clock.
- Control and datapath are merged in one block with a start/done/busy handshake, a perfect-square flag and an exposed state code.
- Used wherever the design needs an integer root of a sensor or accumulator value.

Parameters:
- WIDTH, 20, operand width in bits. Must be even and >= 4; root width is RW = WIDTH/2.
- STATE_W, 2, width of the state output.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it (0) immediately forces reset values.
- sqrt_start  in  1  request; sampled only in IDLE.
- data_in  in  WIDTH  unsigned operand; captured on the accepting edge.
- sqrt_done  out  1  one-cycle pulse: result valid.
- sqrt_busy  out  1  high from the accepting edge until DONE is left.
- data_out  out  RW  floor(sqrt(operand)).
- rem_out  out  RW+1  operand - data_out^2.
- perfect  out  1  high when rem_out == 0; valid with data_out.
- SQRTstate  out  STATE_W  current state code.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE; all outputs 0.
  - Internal operand, root, remainder and counter registers are cleared.
  - A reset asserted mid-computation aborts the operation with no done pulse.
- State encoding: IDLE = 0, ITER = 1, DONE = 2. Code 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - If sqrt_start = 1 at a rising edge: capture data_in into the operand shift register, clear root and partial remainder, set the counter to RW-1, go to ITER, raise sqrt_busy.
  - Otherwise stay in IDLE. data_out, rem_out and perfect hold their last result.
- ITER: one iteration per rising edge.
  - r' = (r << 2) | top two operand bits; operand <<= 2.
  - t = r' - ((q << 2) | 1), evaluated RW+2 bits wide.
  - If t >= 0: r = t, q = (q << 1) | 1. Otherwise r = r', q = q << 1.
  - When the counter = 0, the iteration completes and the state goes to DONE; otherwise the counter decrements.
- DONE, one cycle:
  - data_out = q, rem_out = r[RW:0], perfect = (r == 0), all registered on the DONE entry edge.
  - sqrt_done = 1 and sqrt_busy = 1.
  - Next edge: go to IDLE, sqrt_done = 0, sqrt_busy = 0.
- Latency: the DONE cycle begins RW rising edges after the accepting edge (10 for WIDTH=20). Throughput is one operation per RW+2 cycles.
- sqrt_start in ITER or DONE is ignored; there is no queueing. A new request is accepted the first IDLE edge after DONE.
- data_in changes after the accepting edge do not affect the result.
- Width rules:
  - The remainder always fits in RW+1 bits (max 2*root).
  - The internal subtract is RW+2 bits; the sign bit of t selects restore.
  - No overflow is possible for any operand.
- Outputs change only on rising edges or on reset assertion. Combinational paths from inputs to outputs are not allowed.

Test Plan:
- WIDTH=20; reset low 3 cycles, release; start with data_in = 0 -> done after 10 edges; data_out = 0, rem_out = 0, perfect = 1; busy high exactly 11 cycles.
- WIDTH=20; data_in = 1000 -> data_out = 31, rem_out = 39, perfect = 0. Then data_in = 144 -> data_out = 12, rem_out = 0, perfect = 1.
- WIDTH=20; data_in = 1048575 (max) -> data_out = 1023, rem_out = 2046, perfect = 0. Check no overflow in the remainder.
- Start held high continuously with data_in changed each cycle:
  - only IDLE edges accept;
  - results match the operand captured at each accept edge;
  - done pulses are spaced RW+2 = 12 cycles apart;
  - SQRTstate sequence is 0, 1 (x10), 2, 0.
- Reset asserted asynchronously mid-ITER (5th iteration) -> outputs 0 immediately, state 0, no done pulse. A new start after release yields the correct result.
- WIDTH=8 instance; data_in = 255 -> data_out = 15, rem_out = 30, done 4 edges after the accept edge. data_in = 64 -> data_out = 8, perfect = 1.
